// File: rtl/onehot_decoder_fifo.sv
// Sequential index-to-one-hot decoder. Encoded indices are queued through
// a valid/ready FIFO. Each entry's one-hot (or all-zero) line is driven on
// y for its own hold count, and the next entry follows with no idle gap.
module onehot_decoder_fifo #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD_W = 4,
  localparam int unsigned OUT_W = 1 << IDX_W,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              in_en,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = IDX_W + 1 + HOLD_W;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q;
  logic [HOLD_W-1:0] hcnt_q;
  logic [OUT_W-1:0]  y_q;
  logic              y_valid_q;

  logic              push, pop;
  logic [ENT_W-1:0]  head;
  logic [IDX_W-1:0]  head_idx;
  logic              head_en;
  logic [HOLD_W-1:0] head_hold;
  logic [OUT_W-1:0]  y_load;
  logic [HOLD_W-1:0] hold_load;
  logic              load_slot;

  // Ready depends on occupancy only, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  // A new entry is loaded from IDLE, or on the last cycle of the current hold.
  assign load_slot = (state_q == StIdle) || (hcnt_q == HOLD_W'(1));
  assign pop       = (count_q != '0) && load_slot;

  assign head      = mem[rptr_q];
  assign head_idx  = head[ENT_W-1 -: IDX_W];
  assign head_en   = head[HOLD_W];
  assign head_hold = head[HOLD_W-1:0];
  assign y_load    = head_en ? (OUT_W'(1) << head_idx) : '0;
  assign hold_load = (head_hold == '0) ? HOLD_W'(1) : head_hold;

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign count   = count_q;
  assign busy    = (state_q == StHold) || (count_q != '0);

  // Occupancy next state from push/pop.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {in_idx, in_en, in_hold};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Issue FSM with registered outputs: load head, count down hold, then idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (pop) begin
      state_q   <= StHold;
      hcnt_q    <= hold_load;
      y_q       <= y_load;
      y_valid_q <= 1'b1;
    end else if (state_q == StHold) begin
      if (hcnt_q == HOLD_W'(1)) begin
        state_q   <= StIdle;
        hcnt_q    <= '0;
        y_q       <= '0;
        y_valid_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_q - HOLD_W'(1);
      end
    end
  end

endmodule
